// File: rtl/pu_datapath_param.sv
// Parameterised processing-unit datapath: register file, PC, IR, address and Y
// registers, ALU with registered flags, and a memory-stall detector with sticky timeout.
module pu_datapath_param #(
  parameter int unsigned DATAWIDTH   = 8,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned OPCODE_SIZE = 4,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic [DATAWIDTH-1:0]          mem_word,
  input  logic                          mem_valid,
  input  logic                          ld_reg,
  input  logic [$clog2(NUM_REGS)-1:0]   reg_wr_sel,
  input  logic [$clog2(NUM_REGS+1)-1:0] sel_bus1,
  input  logic [1:0]                    sel_bus2,
  input  logic                          ld_pc,
  input  logic                          inc_pc,
  input  logic                          ld_ir,
  input  logic                          ld_addr,
  input  logic                          ld_y,
  input  logic                          ld_flags,
  input  logic                          clr_err,
  output logic [DATAWIDTH-1:0]          instruction,
  output logic [DATAWIDTH-1:0]          address,
  output logic [DATAWIDTH-1:0]          bus1,
  output logic                          zero_flag,
  output logic                          carry_flag,
  output logic                          neg_flag,
  output logic                          stall,
  output logic                          bus_err
);

  localparam int unsigned RSW  = $clog2(NUM_REGS);
  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0] TO_CNT = CNTW'(TIMEOUT);
  localparam logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'(1);
  localparam logic [OPCODE_SIZE-1:0] OP_SUB = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_AND = OPCODE_SIZE'(3);
  localparam logic [OPCODE_SIZE-1:0] OP_NOT = OPCODE_SIZE'(4);
  localparam logic [1:0] B2_ALU  = 2'd0;
  localparam logic [1:0] B2_BUS1 = 2'd1;
  localparam logic [1:0] B2_MEM  = 2'd2;

  logic [DATAWIDTH-1:0]   regs [NUM_REGS];
  logic [DATAWIDTH-1:0]   pc;
  logic [DATAWIDTH-1:0]   y_reg;
  logic [DATAWIDTH-1:0]   bus2;
  logic [DATAWIDTH-1:0]   alu_res;
  logic [OPCODE_SIZE-1:0] opcode;
  logic                   alu_carry;
  logic                   alu_zero;
  logic                   alu_neg;
  logic [CNTW-1:0]        stall_cnt;
  logic                   err_set;

  assign opcode = instruction[DATAWIDTH-1 -: OPCODE_SIZE];

  // bus1: register file, then PC, out-of-range selects read as zero
  always_comb begin
    bus1 = '0;
    if (32'(sel_bus1) < NUM_REGS) begin
      bus1 = regs[RSW'(sel_bus1)];
    end else if (32'(sel_bus1) == NUM_REGS) begin
      bus1 = pc;
    end
  end

  always_comb begin
    bus2 = '0;
    case (sel_bus2)
      B2_ALU:  bus2 = alu_res;
      B2_BUS1: bus2 = bus1;
      B2_MEM:  bus2 = mem_word;
      default: bus2 = '0;
    endcase
  end

  // ALU: A = bus1, B = Y; carry is carry-out for ADD and borrow for SUB
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opcode)
      OP_ADD:  {alu_carry, alu_res} = {1'b0, bus1} + {1'b0, y_reg};
      OP_SUB: begin
        alu_res   = bus1 - y_reg;
        alu_carry = (bus1 < y_reg);
      end
      OP_AND:  alu_res = bus1 & y_reg;
      OP_NOT:  alu_res = ~bus1;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
    alu_neg  = alu_res[DATAWIDTH-1];
  end

  assign stall   = (sel_bus2 == B2_MEM) && !mem_valid &&
                   (ld_reg || ld_pc || ld_ir || ld_addr || ld_y);
  assign err_set = stall && (stall_cnt >= TO_CNT - CNTW'(1));

  // Architectural state; everything holds while waiting on memory
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      regs        <= '{default: '0};
      pc          <= '0;
      y_reg       <= '0;
      instruction <= '0;
      address     <= '0;
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
      neg_flag    <= 1'b0;
    end else if (!stall) begin
      if (ld_reg && (32'(reg_wr_sel) < NUM_REGS)) regs[reg_wr_sel] <= bus2;
      if (ld_pc) begin
        pc <= bus2;
      end else if (inc_pc) begin
        pc <= pc + DATAWIDTH'(1);
      end
      if (ld_ir)   instruction <= bus2;
      if (ld_addr) address     <= bus2;
      if (ld_y)    y_reg       <= bus2;
      if (ld_flags) begin
        zero_flag  <= alu_zero;
        carry_flag <= alu_carry;
        neg_flag   <= alu_neg;
      end
    end
  end

  // Stall timeout: saturating counter, sticky error with set over clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stall_cnt <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (!stall) begin
        stall_cnt <= '0;
      end else if (stall_cnt < TO_CNT) begin
        stall_cnt <= stall_cnt + CNTW'(1);
      end
      if (err_set) begin
        bus_err <= 1'b1;
      end else if (clr_err) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pu_datapath_param.sv
// Directed bench for pu_datapath_param: an 8-bit/4-register instance with a short
// timeout and a 16-bit/8-register instance, checked against hand-computed values.
module tb_pu_datapath_param;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0]  mem_word_a;
  logic        mem_valid_a, ld_reg_a;
  logic [1:0]  reg_wr_sel_a;
  logic [2:0]  sel_bus1_a;
  logic [1:0]  sel_bus2_a;
  logic        ld_pc_a, inc_pc_a, ld_ir_a, ld_addr_a, ld_y_a, ld_flags_a, clr_err_a;
  logic [7:0]  instruction_a, address_a, bus1_a;
  logic        zero_a, carry_a, neg_a, stall_a, bus_err_a;

  logic [15:0] mem_word_b;
  logic        mem_valid_b, ld_reg_b;
  logic [2:0]  reg_wr_sel_b;
  logic [3:0]  sel_bus1_b;
  logic [1:0]  sel_bus2_b;
  logic        ld_pc_b, inc_pc_b, ld_ir_b, ld_addr_b, ld_y_b, ld_flags_b, clr_err_b;
  logic [15:0] instruction_b, address_b, bus1_b;
  logic        zero_b, carry_b, neg_b, stall_b, bus_err_b;

  pu_datapath_param #(.DATAWIDTH(8), .NUM_REGS(4), .OPCODE_SIZE(4), .TIMEOUT(4)) dut_a (
    .clk(clk), .clr(clr), .mem_word(mem_word_a), .mem_valid(mem_valid_a),
    .ld_reg(ld_reg_a), .reg_wr_sel(reg_wr_sel_a), .sel_bus1(sel_bus1_a), .sel_bus2(sel_bus2_a),
    .ld_pc(ld_pc_a), .inc_pc(inc_pc_a), .ld_ir(ld_ir_a), .ld_addr(ld_addr_a), .ld_y(ld_y_a),
    .ld_flags(ld_flags_a), .clr_err(clr_err_a), .instruction(instruction_a),
    .address(address_a), .bus1(bus1_a), .zero_flag(zero_a), .carry_flag(carry_a),
    .neg_flag(neg_a), .stall(stall_a), .bus_err(bus_err_a)
  );

  pu_datapath_param #(.DATAWIDTH(16), .NUM_REGS(8), .OPCODE_SIZE(4), .TIMEOUT(2)) dut_b (
    .clk(clk), .clr(clr), .mem_word(mem_word_b), .mem_valid(mem_valid_b),
    .ld_reg(ld_reg_b), .reg_wr_sel(reg_wr_sel_b), .sel_bus1(sel_bus1_b), .sel_bus2(sel_bus2_b),
    .ld_pc(ld_pc_b), .inc_pc(inc_pc_b), .ld_ir(ld_ir_b), .ld_addr(ld_addr_b), .ld_y(ld_y_b),
    .ld_flags(ld_flags_b), .clr_err(clr_err_b), .instruction(instruction_b),
    .address(address_b), .bus1(bus1_b), .zero_flag(zero_b), .carry_flag(carry_b),
    .neg_flag(neg_b), .stall(stall_b), .bus_err(bus_err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    mem_word_a = '0; mem_valid_a = 1'b0; ld_reg_a = 1'b0; reg_wr_sel_a = '0;
    sel_bus1_a = '0; sel_bus2_a = '0; ld_pc_a = 1'b0; inc_pc_a = 1'b0; ld_ir_a = 1'b0;
    ld_addr_a = 1'b0; ld_y_a = 1'b0; ld_flags_a = 1'b0; clr_err_a = 1'b0;
  endtask

  task automatic idle_b();
    mem_word_b = '0; mem_valid_b = 1'b0; ld_reg_b = 1'b0; reg_wr_sel_b = '0;
    sel_bus1_b = '0; sel_bus2_b = '0; ld_pc_b = 1'b0; inc_pc_b = 1'b0; ld_ir_b = 1'b0;
    ld_addr_b = 1'b0; ld_y_b = 1'b0; ld_flags_b = 1'b0; clr_err_b = 1'b0;
  endtask

  // Present a valid memory word on bus2 of instance A; caller picks the destination
  task automatic put_a(input logic [7:0] w);
    idle_a();
    sel_bus2_a = 2'd2; mem_valid_a = 1'b1; mem_word_a = w;
  endtask

  initial begin
    clr = 1'b0;
    idle_a();
    idle_b();
    #3;
    chk("rst_ir_a", 32'(instruction_a), 0);
    chk("rst_addr_a", 32'(address_a), 0);
    chk("rst_bus1_a", 32'(bus1_a), 0);
    chk("rst_flags_a", 32'({zero_a, carry_a, neg_a}), 0);
    chk("rst_err_a", 32'(bus_err_a), 0);
    chk("rst_stall_a", 32'(stall_a), 0);
    chk("rst_ir_b", 32'(instruction_b), 0);
    #3 clr = 1'b1;
    tick();

    // Instance B: wide word, high register index, multi-destination load
    sel_bus2_b = 2'd2; mem_valid_b = 1'b1; mem_word_b = 16'h1234; ld_ir_b = 1'b1;
    tick();
    mem_word_b = 16'hBEEF; ld_ir_b = 1'b0; ld_reg_b = 1'b1; reg_wr_sel_b = 3'd7; ld_addr_b = 1'b1;
    tick();
    idle_b(); sel_bus1_b = 4'd7; #1;
    chk("b_bus1_r7", 32'(bus1_b), 32'hBEEF);
    chk("b_addr", 32'(address_b), 32'hBEEF);
    chk("b_ir", 32'(instruction_b), 32'h1234);
    ld_flags_b = 1'b1;
    tick();
    chk("b_neg", 32'(neg_b), 1);
    ld_flags_b = 1'b0;

    // ADD 0x7F + 0x01
    put_a(8'h7F); ld_reg_a = 1'b1; reg_wr_sel_a = 2'd0; tick();
    put_a(8'h01); ld_y_a = 1'b1; tick();
    put_a(8'h10); ld_ir_a = 1'b1; tick();
    idle_a(); #1;
    chk("ir_add", 32'(instruction_a), 32'h10);
    chk("bus1_r0", 32'(bus1_a), 32'h7F);
    ld_reg_a = 1'b1; reg_wr_sel_a = 2'd1; ld_flags_a = 1'b1;
    tick();
    chk("add_flags", 32'({zero_a, carry_a, neg_a}), 32'b001);
    idle_a(); sel_bus1_a = 3'd1; #1;
    chk("add_r1", 32'(bus1_a), 32'h80);

    // ADD carry-out: 0x7F + 0xFF = 0x17E
    put_a(8'hFF); ld_y_a = 1'b1; tick();
    idle_a(); ld_flags_a = 1'b1; tick();
    chk("add_carry", 32'({zero_a, carry_a, neg_a}), 32'b010);

    // SUB 0x03 - 0x05 then 0x05 - 0x05
    put_a(8'h03); ld_reg_a = 1'b1; reg_wr_sel_a = 2'd2; tick();
    put_a(8'h05); ld_y_a = 1'b1; tick();
    put_a(8'h20); ld_ir_a = 1'b1; tick();
    idle_a(); sel_bus1_a = 3'd2; ld_reg_a = 1'b1; reg_wr_sel_a = 2'd3; ld_flags_a = 1'b1;
    tick();
    chk("sub_borrow", 32'({zero_a, carry_a, neg_a}), 32'b011);
    idle_a(); sel_bus1_a = 3'd3; #1;
    chk("sub_r3", 32'(bus1_a), 32'hFE);
    put_a(8'h05); ld_reg_a = 1'b1; reg_wr_sel_a = 2'd2; tick();
    idle_a(); sel_bus1_a = 3'd2; ld_flags_a = 1'b1; tick();
    chk("sub_zero", 32'({zero_a, carry_a, neg_a}), 32'b100);

    // NOT of 0x05 = 0xFA, then undefined opcode yields 0
    put_a(8'h40); ld_ir_a = 1'b1; tick();
    idle_a(); sel_bus1_a = 3'd2; ld_flags_a = 1'b1; tick();
    chk("not_flags", 32'({zero_a, carry_a, neg_a}), 32'b001);
    put_a(8'hF0); ld_ir_a = 1'b1; tick();
    idle_a(); sel_bus1_a = 3'd2; ld_flags_a = 1'b1; tick();
    chk("undef_flags", 32'({zero_a, carry_a, neg_a}), 32'b100);

    // PC wrap, pre-edge read, ld_pc priority
    put_a(8'hFF); ld_pc_a = 1'b1; tick();
    idle_a(); sel_bus1_a = 3'd4; #1;
    chk("pc_ff", 32'(bus1_a), 32'hFF);
    inc_pc_a = 1'b1; #1;
    chk("pc_pre_edge", 32'(bus1_a), 32'hFF);
    tick();
    chk("pc_wrap", 32'(bus1_a), 32'h00);
    put_a(8'h40); ld_pc_a = 1'b1; inc_pc_a = 1'b1; tick();
    idle_a(); sel_bus1_a = 3'd4; #1;
    chk("pc_ld_prio", 32'(bus1_a), 32'h40);

    put_a(8'h3C); ld_addr_a = 1'b1; ld_reg_a = 1'b1; reg_wr_sel_a = 2'd0; tick();
    idle_a(); #1;
    chk("addr", 32'(address_a), 32'h3C);
    chk("multi_r0", 32'(bus1_a), 32'h3C);

    // Three-cycle memory wait on an IR load with inc_pc requested
    idle_a(); sel_bus2_a = 2'd2; mem_word_a = 8'hA5; ld_ir_a = 1'b1; inc_pc_a = 1'b1;
    sel_bus1_a = 3'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_on", 32'(stall_a), 1);
      tick();
      chk("stall_ir_hold", 32'(instruction_a), 32'hF0);
      chk("stall_pc_hold", 32'(bus1_a), 32'h40);
    end
    mem_valid_a = 1'b1; #1;
    chk("stall_off", 32'(stall_a), 0);
    tick();
    chk("ir_a5", 32'(instruction_a), 32'hA5);
    chk("pc_inc_after", 32'(bus1_a), 32'h41);
    chk("no_err_short", 32'(bus_err_a), 0);

    // Timeout: six stalled cycles, clr_err collides with set on the 5th
    idle_a(); sel_bus2_a = 2'd2; ld_y_a = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      clr_err_a = (i == 5);
      tick();
      chk("timeout", 32'(bus_err_a), (i >= 4) ? 32'd1 : 32'd0);
    end
    idle_a(); tick();
    chk("err_sticky", 32'(bus_err_a), 1);
    clr_err_a = 1'b1; tick();
    chk("err_clr", 32'(bus_err_a), 0);

    // Reset asserted in the middle of a stall on both instances
    idle_a(); sel_bus2_a = 2'd2; ld_ir_a = 1'b1;
    idle_b(); sel_bus2_b = 2'd2; ld_y_b = 1'b1; sel_bus1_b = 4'd7;
    tick();
    tick();
    chk("b_err_set", 32'(bus_err_b), 1);
    chk("a_stalled", 32'(stall_a), 1);
    #2 clr = 1'b0;
    #1;
    chk("mid_rst_ir_a", 32'(instruction_a), 0);
    chk("mid_rst_addr_a", 32'(address_a), 0);
    chk("mid_rst_bus1_a", 32'(bus1_a), 0);
    chk("mid_rst_flags_a", 32'({zero_a, carry_a, neg_a}), 0);
    chk("mid_rst_ir_b", 32'(instruction_b), 0);
    chk("mid_rst_addr_b", 32'(address_b), 0);
    chk("mid_rst_bus1_b", 32'(bus1_b), 0);
    chk("mid_rst_flags_b", 32'({zero_b, carry_b, neg_b}), 0);
    chk("mid_rst_err_b", 32'(bus_err_b), 0);
    #2 clr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("restart_cnt", 32'(bus_err_a), (i == 4) ? 32'd1 : 32'd0);
    end
    idle_a();
    idle_b();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
